// File: rtl/trigger_readout_scheduler_pkg.sv
// Shared definitions for the trigger readout scheduler: channel count, FSM encoding,
// trigger-info field positions inside the FIFO word and the event header layout.
package trigger_readout_scheduler_pkg;

  localparam int NUM_CHAN = 5;
  localparam int IDX_W    = $clog2(NUM_CHAN);
  localparam int PTR_W    = $clog2(NUM_CHAN + 1);

  localparam int FIFO_W = 128;
  localparam int TS_LSB = 0;
  localparam int TS_W   = 44;
  localparam int TN_LSB = 44;
  localparam int TN_W   = 24;
  localparam int TL_LSB = 68;
  localparam int TL_W   = 2;
  localparam int INFO_W = TL_LSB + TL_W;

  localparam int HDR_W     = 128;
  localparam int HDR_PAD_W = HDR_W - NUM_CHAN - INFO_W;

  localparam int WD_W   = 16;
  localparam int TCNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEADER    = 3'd1,
    ST_SCAN      = 3'd2,
    ST_REQ       = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  typedef struct packed {
    logic [TL_W-1:0] trig_length;
    logic [TN_W-1:0] trig_num;
    logic [TS_W-1:0] timestamp;
  } trig_info_t;

  function automatic logic [HDR_W-1:0] build_header(input logic [NUM_CHAN-1:0] en,
                                                    input trig_info_t info);
    return {en, {HDR_PAD_W{1'b0}}, info.trig_length, info.trig_num, info.timestamp};
  endfunction

  function automatic logic [NUM_CHAN-1:0] chan_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CHAN-1:0] oh;
    for (int i = 0; i < NUM_CHAN; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/trigger_readout_scheduler_next_chan_select.sv
// Combinational search for the lowest enabled channel index at or above the pointer.
module next_chan_select
  import trigger_readout_scheduler_pkg::*;
#(
  parameter int N_CH  = NUM_CHAN,
  parameter int I_W   = IDX_W,
  parameter int P_W   = PTR_W
) (
  input  logic [N_CH-1:0] en_mask,
  input  logic [P_W-1:0]  ptr,
  output logic            found,
  output logic [I_W-1:0]  idx
);

  // Walk downwards so the last hit written is the lowest qualifying index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[i] && (P_W'(i) >= ptr)) begin
        found = 1'b1;
        idx   = I_W'(i);
      end
    end
  end

endmodule

// File: rtl/trigger_readout_scheduler.sv
// Pops one trigger word per event, sends its header, then walks the enabled channels
// in ascending order issuing readout requests with a per-channel watchdog.
//   state     | meaning
//   IDLE      | waiting for a trigger word; latch it and pop
//   HEADER    | offering the event header until accepted
//   SCAN      | looking for the next enabled channel
//   REQ       | requesting the selected channel until it acks
//   WAIT_DONE | waiting for done or the watchdog limit
//   DONE      | one-cycle event-complete pulse
module trigger_readout_scheduler
  import trigger_readout_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_valid,
  input  logic [FIFO_W-1:0]   fifo_data,
  output logic                fifo_ready,
  input  logic [NUM_CHAN-1:0] chan_en,
  output logic [NUM_CHAN-1:0] chan_req,
  input  logic [NUM_CHAN-1:0] chan_ack,
  input  logic [NUM_CHAN-1:0] chan_done,
  input  logic [WD_W-1:0]     chan_timeout,
  output logic                hdr_valid,
  output logic [HDR_W-1:0]    hdr_data,
  input  logic                hdr_ready,
  output logic                readout_done,
  output logic [2:0]          state,
  output logic [TCNT_W-1:0]   timeout_count
);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  trig_info_t          info_q, info_d;
  logic [NUM_CHAN-1:0] en_q, en_d;
  logic                fifo_ready_q, fifo_ready_d;

  logic                scan_found;
  logic [IDX_W-1:0]    scan_idx;
  logic [NUM_CHAN-1:0] sel_oh;
  logic                sel_ack;
  logic                sel_done;
  logic [PTR_W-1:0]    ptr_after_sel;
  logic [WD_W-1:0]     wd_limit;
  logic                wd_expired;
  logic                unused_fifo_hi;

  next_chan_select #(
    .N_CH (NUM_CHAN),
    .I_W  (IDX_W),
    .P_W  (PTR_W)
  ) u_next_chan_select (
    .en_mask (en_q),
    .ptr     (ptr_q),
    .found   (scan_found),
    .idx     (scan_idx)
  );

  // Only the selected channel's handshake bits are ever looked at.
  assign sel_oh        = chan_onehot(sel_q);
  assign sel_ack       = |(chan_ack & sel_oh);
  assign sel_done      = |(chan_done & sel_oh);
  assign ptr_after_sel = PTR_W'(sel_q) + PTR_W'(1);

  // >= rather than == so a limit lowered mid-wait still releases the channel.
  assign wd_limit   = chan_timeout - WD_W'(1);
  assign wd_expired = (chan_timeout != '0) && (wd_q >= wd_limit);

  assign unused_fifo_hi = ^fifo_data[FIFO_W-1:INFO_W];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    wd_d         = wd_q;
    tcnt_d       = tcnt_q;
    info_d       = info_q;
    en_d         = en_q;
    fifo_ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_valid) begin
          fifo_ready_d       = 1'b1;
          info_d.timestamp   = fifo_data[TS_LSB +: TS_W];
          info_d.trig_num    = fifo_data[TN_LSB +: TN_W];
          info_d.trig_length = fifo_data[TL_LSB +: TL_W];
          en_d               = chan_en;
          ptr_d              = '0;
          state_d            = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (hdr_ready) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_found) begin
          sel_d   = scan_idx;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (sel_ack) begin
          if (sel_done) begin
            ptr_d   = ptr_after_sel;
            state_d = ST_SCAN;
          end else begin
            wd_d    = '0;
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (sel_done) begin
          ptr_d   = ptr_after_sel;
          state_d = ST_SCAN;
        end else if (wd_expired) begin
          tcnt_d  = tcnt_q + TCNT_W'(1);
          ptr_d   = ptr_after_sel;
          state_d = ST_SCAN;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      wd_q         <= '0;
      tcnt_q       <= '0;
      info_q       <= '0;
      en_q         <= '0;
      fifo_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      wd_q         <= wd_d;
      tcnt_q       <= tcnt_d;
      info_q       <= info_d;
      en_q         <= en_d;
      fifo_ready_q <= fifo_ready_d;
    end
  end

  // Every handshake output comes from flops or the state register.
  assign fifo_ready    = fifo_ready_q;
  assign hdr_valid     = (state_q == ST_HEADER);
  assign hdr_data      = build_header(en_q, info_q);
  assign chan_req      = (state_q == ST_REQ) ? sel_oh : '0;
  assign readout_done  = (state_q == ST_DONE);
  assign state         = state_q;
  assign timeout_count = tcnt_q;

endmodule

// File: doc/trigger_readout_scheduler.md
TRIGGER_READOUT_SCHEDULER -- requirements
Module: trigger_readout_scheduler

Interface
REQ-001 SHALL have clk  in  1  40 MHz TTC clock; reset reset, synchronous, active-high; clock clk.
REQ-002 SHALL have reset  in  1  synchronous active-high reset.
REQ-003 SHALL have fifo_valid  in  1  trigger-info FIFO non-empty (first-word-fall-through).
REQ-004 SHALL have fifo_data  in  128  trigger info: [43:0] timestamp, [67:44] trig_num, [69:68] trig_length.
REQ-005 SHALL have fifo_ready  out  1  pop strobe to trigger-info FIFO.
REQ-006 SHALL have chan_en  in  5  enabled channels, sampled at pop.
REQ-007 SHALL have chan_req  out  5  one-hot readout request to channel.
REQ-008 SHALL have chan_ack  in  5  channel accepted request.
REQ-009 SHALL have chan_done  in  5  channel finished readout.
REQ-010 SHALL have chan_timeout  in  16  watchdog limit in cycles; 0 disables.
REQ-011 SHALL have hdr_valid  out  1 and hdr_data  out  128  event header to readout path.
REQ-012 SHALL have hdr_ready  in  1  readout path accepts header.
REQ-013 SHALL have readout_done  out  1  one-cycle pulse, event complete.
REQ-014 SHALL have state  out  3  current state encoding; timeout_count  out  32  channel timeouts.

Function
REQ-015 States SHALL be IDLE, HEADER, SCAN, REQ, WAIT_DONE, DONE, binary encoded 0..5.
REQ-016 IDLE: fifo_valid=1 -> fifo_ready=1 for exactly one cycle, latch fifo_data[69:0] and chan_en, clear channel pointer, -> HEADER; fifo_valid=0 -> stay.
REQ-017 HEADER: hdr_valid=1, hdr_data={latched chan_en, 53'd0, trig_length, trig_num, timestamp}, held stable until hdr_valid&hdr_ready; transfer cycle -> SCAN.
REQ-018 SCAN: select lowest latched-enabled channel index >= pointer -> REQ; none -> DONE; one cycle.
REQ-019 REQ: chan_req bit of selected channel =1 until its chan_ack; ack cycle clears watchdog -> WAIT_DONE.
REQ-020 REQ: chan_ack and chan_done of selected channel in same cycle -> channel complete, pointer=index+1 -> SCAN.
REQ-021 WAIT_DONE: chan_done of selected channel -> pointer=index+1 -> SCAN; watchdog increments each cycle otherwise.
REQ-022 WAIT_DONE: chan_timeout!=0 and watchdog==chan_timeout-1 without done -> timeout_count+1 (wraps at 2^32), pointer=index+1 -> SCAN.
REQ-023 chan_ack/chan_done bits of non-selected channels SHALL be ignored in every state.
REQ-024 DONE: readout_done=1 for one cycle -> IDLE; fifo_ready SHALL NOT assert in DONE (min 1 idle cycle between events).
REQ-025 Latched chan_en=0: header still sent, SCAN finds none, DONE; event consumed without channel requests.
REQ-026 chan_en changes after pop SHALL NOT affect the in-progress event.
REQ-027 Watchdog SHALL be 16 bits, reset on entry to WAIT_DONE, never wrap (saturates at limit).
REQ-028 fifo_ready, chan_req, hdr_valid, readout_done SHALL be registered or decoded from state only (no combinational path from inputs).

Reset
REQ-029 Reset SHALL force state=IDLE, fifo_ready=0, chan_req=0, hdr_valid=0, hdr_data=0, readout_done=0, timeout_count=0, watchdog=0, pointer=0, latched fields=0.
REQ-030 Reset mid-event SHALL abandon event without readout_done; popped FIFO word is lost.

Structure
REQ-031 Shared package SHALL hold NUM_CHAN=5, state encodings, fifo_data field bit positions, header layout widths.
REQ-032 Sub-module next_chan_select SHALL implement combinational lowest-enabled-index-at-or-above-pointer search with found flag.

Verification
REQ-033 chan_en=5'b10101, one FIFO word, hdr_ready=1, acks/dones in 2 cycles -> header once, chan_req 0x01,0x04,0x10 in order, one readout_done.
REQ-034 hdr_ready held 0 for 10 cycles -> hdr_valid and hdr_data stable all 10 cycles, no chan_req until transfer.
REQ-035 chan_timeout=8, channel 2 never done -> released after 8 WAIT_DONE cycles, timeout_count=1, channel 3 requested next.
REQ-036 chan_en=0 with word queued -> fifo_ready pulse, header with enable field 0, readout_done, zero chan_req.
REQ-037 Two back-to-back FIFO words, chan_en toggled mid-event -> first event uses pop-time enables, second pop only after readout_done.
REQ-038 reset asserted in WAIT_DONE -> next cycle all outputs at reset values, no readout_done pulse.
